// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS instruction field layout, NOP default and IF/ID occupancy states
package mips_pkg;

   localparam int INSTR_W    = 32;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int OPCODE_W   = 6;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int REG_W      = 5;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int SHAMT_W    = 5;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int FUNCT_W    = 6;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;
   localparam int IMM_W      = 16;

   // sll $0,$0,0
   localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

endpackage

// File: rtl/instr_fields.sv
// rtl/instr_fields.sv - combinational slicer of a 32-bit MIPS word into its fields
module instr_fields
   import mips_pkg::*;
(
   input  logic [INSTR_W-1:0]  instr,
   output logic [OPCODE_W-1:0] opcode,
   output logic [REG_W-1:0]    rs,
   output logic [REG_W-1:0]    rt,
   output logic [REG_W-1:0]    rd,
   output logic [SHAMT_W-1:0]  shamt,
   output logic [FUNCT_W-1:0]  funct,
   output logic [IMM_W-1:0]    imm16
);

   // Pure slices; extension happens downstream in sign_extend.
   assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
   assign rs     = instr[RS_MSB:RS_LSB];
   assign rt     = instr[RT_MSB:RT_LSB];
   assign rd     = instr[RD_MSB:RD_LSB];
   assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
   assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
   assign imm16  = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with flush; IFID_SKID_EN adds a skid entry and registered in_ready
module if_id_register
   import mips_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INSTR_W-1:0]  in_instr,
   input  logic [ADDR_W-1:0]   in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [INSTR_W-1:0]  out_instr,
   output logic [ADDR_W-1:0]   out_pc,
   output logic [OPCODE_W-1:0] out_opcode,
   output logic [REG_W-1:0]    out_rs,
   output logic [REG_W-1:0]    out_rt,
   output logic [REG_W-1:0]    out_rd,
   output logic [SHAMT_W-1:0]  out_shamt,
   output logic [FUNCT_W-1:0]  out_funct,
   output logic [IMM_W-1:0]    out_imm16
);

   occ_state_t         state, state_d;
   logic [INSTR_W-1:0] main_instr;
   logic [ADDR_W-1:0]  main_pc;
   logic               xfer_in, xfer_out;
   logic               load_main;

   assign out_valid = (state != OCC_EMPTY);
   assign xfer_in   = in_valid && in_ready;
   assign xfer_out  = out_valid && out_ready;

`ifdef IFID_SKID_EN
   logic [INSTR_W-1:0] skid_instr;
   logic [ADDR_W-1:0]  skid_pc;
   logic               load_skid, skid_to_main;
   logic               in_ready_q;

   assign in_ready = in_ready_q;
`else
   assign in_ready = !out_valid || out_ready;
`endif

   always_comb begin
      state_d   = state;
      load_main = 1'b0;
`ifdef IFID_SKID_EN
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
`endif
      case (state)
         OCC_EMPTY: begin
            if (xfer_in) begin
               state_d   = OCC_ONE;
               load_main = 1'b1;
            end
         end
         OCC_ONE: begin
            if (xfer_in && xfer_out) begin
               load_main = 1'b1;
`ifdef IFID_SKID_EN
            end else if (xfer_in) begin
               state_d   = OCC_TWO;
               load_skid = 1'b1;
`endif
            end else if (xfer_out) begin
               state_d = OCC_EMPTY;
            end
         end
`ifdef IFID_SKID_EN
         OCC_TWO: begin
            if (xfer_out) begin
               state_d      = OCC_ONE;
               skid_to_main = 1'b1;
            end
         end
`endif
         default: state_d = OCC_EMPTY;
      endcase
      // Flush drops everything; suppressing loads keeps out_pc at its last value.
      if (flush) begin
         state_d   = OCC_EMPTY;
         load_main = 1'b0;
`ifdef IFID_SKID_EN
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= OCC_EMPTY;
         main_instr <= NOP_WORD;
         main_pc    <= '0;
      end else begin
         state <= state_d;
         if (load_main) begin
            main_instr <= in_instr;
            main_pc    <= in_pc;
         end
`ifdef IFID_SKID_EN
         else if (skid_to_main) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
         end
`endif
      end
   end

`ifdef IFID_SKID_EN
   // in_ready stays low for the whole cycle in which the skid word drains into main.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_instr <= NOP_WORD;
         skid_pc    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (load_skid) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
         end
         in_ready_q <= (state != OCC_TWO) && (state_d != OCC_TWO);
      end
   end
`endif

   assign out_instr = out_valid ? main_instr : NOP_WORD;
   assign out_pc    = main_pc;

   instr_fields u_fields (
      .instr  (out_instr),
      .opcode (out_opcode),
      .rs     (out_rs),
      .rt     (out_rt),
      .rd     (out_rd),
      .shamt  (out_shamt),
      .funct  (out_funct),
      .imm16  (out_imm16)
   );

endmodule

// File: doc/if_id_register.md
# if_id_register

Fetch-to-decode pipeline register for the MIPS datapath. Accepts 32-bit instruction words and their PC from the fetch stage over a valid/ready handshake, holds them across decode stalls, and presents the registered word plus its split fields to decode. `out_imm16` drives the `sign_extend` block directly. The block supports flush for branch and jump redirects.

## Interface
- `ADDR_W`, 32: PC width in bits.
- `NOP_WORD`, 32'h0000_0000: word driven on `out_instr` when no valid instruction is held (`sll $0,$0,0`).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: discard all held and incoming instructions.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: register can accept this cycle.
- `in_instr` input 32: instruction word.
- `in_pc` input ADDR_W: PC of `in_instr`.
- `out_valid` output 1: decode-side instruction valid.
- `out_ready` input 1: decode consumes this cycle.
- `out_instr` output 32: held instruction.
- `out_pc` output ADDR_W: held PC.
- `out_opcode` output 6: `out_instr[31:26]`.
- `out_rs` output 5: bits [25:21].
- `out_rt` output 5: bits [20:16].
- `out_rd` output 5: bits [15:11].
- `out_shamt` output 5: bits [10:6].
- `out_funct` output 6: bits [5:0].
- `out_imm16` output 16: bits [15:0]; feeds `sign_extend.immediate`.

## Operation
- Transfer in: `in_valid && in_ready` on an edge. Transfer out: `out_valid && out_ready` on an edge.
- Occupancy states: EMPTY, ONE, TWO. TWO exists only with the skid build (see Configuration).
  - EMPTY to ONE on transfer in.
  - ONE to EMPTY on transfer out with no transfer in.
  - ONE stays ONE on simultaneous transfer in and out; the main register loads the new word.
  - ONE to TWO on transfer in without transfer out; the word goes to the skid register.
  - TWO to ONE on transfer out; the skid word moves to the main register.
- Ordering is strictly FIFO. No word is duplicated or dropped except by `flush`.
- `flush` has priority over everything:
  - the next state is EMPTY;
  - a transfer in during the flush cycle is discarded;
  - the output handshake in the flush cycle still completes normally for decode.
- When `out_valid` = 0, `out_instr` = `NOP_WORD` and `out_pc` holds its last value.
- Field outputs are pure slices of `out_instr`. No sign or zero extension is done here; width grows only in `sign_extend`.
- Outputs must not change while `out_valid && !out_ready`.

## Timing
- Latency: an instruction accepted at edge N is visible at `out_*` after edge N; minimum 1 cycle.
- Throughput: one instruction per cycle while `out_ready` = 1.
- Reset values:
  - `out_valid` = 0, `out_instr` = `NOP_WORD`, `out_pc` = 0;
  - all field outputs are the slices of `NOP_WORD`;
  - `in_ready` = 1;
  - skid register cleared.
- Reset asserted mid-operation drops all held words immediately, asynchronously.
- Skid build: `in_ready` is registered and equals "not TWO". It falls the cycle after entering TWO and rises the cycle after leaving TWO.
- Non-skid build: `in_ready` = `!out_valid || out_ready` (combinational path from `out_ready`).

## Configuration
- `IFID_SKID_EN` defined:
  - two-entry skid buffer with registered `in_ready`;
  - no combinational path from `out_ready` to `in_ready`.
- `IFID_SKID_EN` undefined:
  - single register, states EMPTY and ONE only;
  - `in_ready` is combinational as stated under Timing;
  - identical ordering and flush behaviour.

## Structure
- Shared package `mips_pkg` holds:
  - field position and width constants (`OPCODE_MSB`, `RS_LSB`, `IMM_W` = 16, and so on);
  - the `NOP_WORD` default;
  - the occupancy state enum.
- One sub-module, `instr_fields`: combinational slicer from the 32-bit word to opcode/rs/rt/rd/shamt/funct/imm16. Instantiated on `out_instr`.

## Test plan
- Reset: hold `rst_n` = 0 → `out_valid` = 0, `out_instr` = 0, `in_ready` = 1. Release, no input → state unchanged.
- Streaming: `out_ready` = 1, present `addi $t0,$zero,-8` (32'h2008FFF8) at PC 0x0 → next cycle `out_opcode` = 6'h08, `out_rt` = 8, `out_imm16` = 16'hFFF8, `out_pc` = 0. Then 10 back-to-back words → one out per cycle, in order.
- Stall:
  - `out_ready` = 0, send A = 32'h0000_0001 and B = 32'h0000_0002 → skid build: `in_ready` = 0 after B; outputs hold A.
  - Raise `out_ready` → A then B on consecutive cycles; `in_ready` rises the cycle after B reaches main.
- Flush in TWO: flush with `in_valid` = 1 carrying C = 32'h0000_0003 → next cycle `out_valid` = 0, `out_instr` = `NOP_WORD`. C never appears.
- Async reset mid-stream: assert `rst_n` between edges while ONE → `out_valid` drops before the next edge. After release, the first new word appears with 1-cycle latency.
- Non-skid build: repeat the stall scenario → `in_ready` follows `!out_valid || out_ready` in the same cycle; B is held off until A is consumed.
